// File: rtl/axi_sched_pkg.sv
// Shared types and constants for the I/D cache AXI burst scheduler.
package axi_sched_pkg;

  typedef enum logic [1:0] {R_IDLE, R_ADDR, R_DATA} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} w_state_e;

  localparam logic       ID_ICACHE  = 1'b0;
  localparam logic       ID_DCACHE  = 1'b1;
  localparam logic [1:0] BURST_INCR = 2'b01;
  localparam logic [2:0] SIZE_WORD  = 3'b010;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the icache, bit 1 the dcache.
module rr_arb2
  import axi_sched_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic       gnt_o,
  output logic       gnt_id_o
);

  logic last_q, last_d;
  logic pick;

  always_comb begin
    pick = req_i[1];
    if (req_i == 2'b11) pick = ~last_q;
    gnt_o    = en_i & (|req_i);
    gnt_id_o = pick;
    last_d   = gnt_o ? pick : last_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) last_q <= ID_ICACHE;
    else         last_q <= last_d;
  end

endmodule

// File: rtl/axi_burst_scheduler.sv
// Shares one AXI3 master between icache (read) and dcache (read/write); reads to a line
// being written are held back until that write's B handshake.
//   state  | meaning
//   R_IDLE | no read owner, arbitrating
//   R_ADDR | AR presented for the latched owner
//   R_DATA | beats routed to the owner until rlast
//   W_IDLE | no write in flight
//   W_ADDR | AW presented
//   W_DATA | W beats pass through
//   W_RESP | waiting for B
module axi_burst_scheduler
  import axi_sched_pkg::*;
#(
  parameter int LINE_OFF = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [31:0] i_araddr_i,
  input  logic [3:0]  i_arlen_i,
  input  logic        i_arvalid_i,
  output logic        i_arready_o,
  output logic [31:0] i_rdata_o,
  output logic        i_rlast_o,
  output logic        i_rvalid_o,
  input  logic        i_rready_i,
  input  logic [31:0] d_araddr_i,
  input  logic [3:0]  d_arlen_i,
  input  logic [2:0]  d_arsize_i,
  input  logic        d_arvalid_i,
  output logic        d_arready_o,
  output logic [31:0] d_rdata_o,
  output logic        d_rlast_o,
  output logic        d_rvalid_o,
  input  logic        d_rready_i,
  input  logic [31:0] d_awaddr_i,
  input  logic [3:0]  d_awlen_i,
  input  logic [2:0]  d_awsize_i,
  input  logic        d_awvalid_i,
  output logic        d_awready_o,
  input  logic [31:0] d_wdata_i,
  input  logic [3:0]  d_wstrb_i,
  input  logic        d_wlast_i,
  input  logic        d_wvalid_i,
  output logic        d_wready_o,
  output logic        d_bvalid_o,
  input  logic        d_bready_i,
  output logic [3:0]  arid_o,
  output logic [31:0] araddr_o,
  output logic [3:0]  arlen_o,
  output logic [2:0]  arsize_o,
  output logic [1:0]  arburst_o,
  output logic [1:0]  arlock_o,
  output logic [3:0]  arcache_o,
  output logic [2:0]  arprot_o,
  output logic        arvalid_o,
  input  logic        arready_i,
  input  logic [3:0]  rid_i,
  input  logic [31:0] rdata_i,
  input  logic [1:0]  rresp_i,
  input  logic        rlast_i,
  input  logic        rvalid_i,
  output logic        rready_o,
  output logic [3:0]  awid_o,
  output logic [31:0] awaddr_o,
  output logic [3:0]  awlen_o,
  output logic [2:0]  awsize_o,
  output logic [1:0]  awburst_o,
  output logic [1:0]  awlock_o,
  output logic [3:0]  awcache_o,
  output logic [2:0]  awprot_o,
  output logic        awvalid_o,
  input  logic        awready_i,
  output logic [3:0]  wid_o,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstrb_o,
  output logic        wlast_o,
  output logic        wvalid_o,
  input  logic        wready_i,
  input  logic [3:0]  bid_i,
  input  logic [1:0]  bresp_i,
  input  logic        bvalid_i,
  output logic        bready_o,
  output logic        err_o
);

  r_state_e    r_state_q, r_state_d;
  logic        owner_q, owner_d;
  logic [31:0] araddr_q, araddr_d;
  logic [3:0]  arlen_q, arlen_d;
  logic [2:0]  arsize_q, arsize_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        err_q, err_d;

  w_state_e    w_state_q, w_state_d;
  logic [31:0] awaddr_q, awaddr_d;
  logic [3:0]  awlen_q, awlen_d;
  logic [2:0]  awsize_q, awsize_d;

  logic haz_i, haz_d, gnt, gnt_id, r_beat, in_rdata, in_wdata, in_wresp;
  logic unused_ok;

  assign unused_ok = ^{rid_i, rresp_i, bid_i, bresp_i};

  // A read may not overtake a write to the same line still in flight.
  assign haz_i = (w_state_q != W_IDLE) &&
                 (i_araddr_i[31:LINE_OFF] == awaddr_q[31:LINE_OFF]);
  assign haz_d = (w_state_q != W_IDLE) &&
                 (d_araddr_i[31:LINE_OFF] == awaddr_q[31:LINE_OFF]);

  rr_arb2 u_arb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (r_state_q == R_IDLE),
    .req_i    ({d_arvalid_i & ~haz_d, i_arvalid_i & ~haz_i}),
    .gnt_o    (gnt),
    .gnt_id_o (gnt_id)
  );

  assign in_rdata = (r_state_q == R_DATA);
  assign rready_o = in_rdata & ((owner_q == ID_DCACHE) ? d_rready_i : i_rready_i);
  assign r_beat   = rvalid_i & rready_o;

  always_comb begin
    r_state_d = r_state_q;
    owner_d   = owner_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    arsize_d  = arsize_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    case (r_state_q)
      R_IDLE: if (gnt) begin
        owner_d   = gnt_id;
        cnt_d     = 4'd0;
        r_state_d = R_ADDR;
        if (gnt_id == ID_DCACHE) begin
          araddr_d = d_araddr_i;
          arlen_d  = d_arlen_i;
          arsize_d = d_arsize_i;
        end else begin
          araddr_d = i_araddr_i;
          arlen_d  = i_arlen_i;
          arsize_d = SIZE_WORD;
        end
      end
      R_ADDR: if (arready_i) r_state_d = R_DATA;
      R_DATA: if (r_beat) begin
        cnt_d = cnt_q + 4'd1;
        if (rlast_i != (cnt_q == arlen_q)) err_d = 1'b1;
        if (rlast_i) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign in_wdata = (w_state_q == W_DATA);
  assign in_wresp = (w_state_q == W_RESP);

  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    awlen_d   = awlen_q;
    awsize_d  = awsize_q;
    case (w_state_q)
      W_IDLE: if (d_awvalid_i) begin
        awaddr_d  = d_awaddr_i;
        awlen_d   = d_awlen_i;
        awsize_d  = d_awsize_i;
        w_state_d = W_ADDR;
      end
      W_ADDR: if (awready_i) w_state_d = W_DATA;
      W_DATA: if (d_wvalid_i && wready_i && d_wlast_i) w_state_d = W_RESP;
      W_RESP: if (bvalid_i && d_bready_i) w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state_q <= R_IDLE;
      owner_q   <= ID_ICACHE;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
      cnt_q     <= '0;
      err_q     <= 1'b0;
      w_state_q <= W_IDLE;
      awaddr_q  <= '0;
      awlen_q   <= '0;
      awsize_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      owner_q   <= owner_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      w_state_q <= w_state_d;
      awaddr_q  <= awaddr_d;
      awlen_q   <= awlen_d;
      awsize_q  <= awsize_d;
    end
  end

  assign arvalid_o   = (r_state_q == R_ADDR);
  assign arid_o      = {3'b000, owner_q};
  assign araddr_o    = araddr_q;
  assign arlen_o     = arlen_q;
  assign arsize_o    = arsize_q;
  assign arburst_o   = BURST_INCR;
  assign arlock_o    = 2'b00;
  assign arcache_o   = 4'b0000;
  assign arprot_o    = 3'b000;
  assign i_arready_o = arready_i & arvalid_o & (owner_q == ID_ICACHE);
  assign d_arready_o = arready_i & arvalid_o & (owner_q == ID_DCACHE);

  assign i_rvalid_o = in_rdata & (owner_q == ID_ICACHE) & rvalid_i;
  assign i_rlast_o  = in_rdata & (owner_q == ID_ICACHE) & rlast_i;
  assign i_rdata_o  = (in_rdata && owner_q == ID_ICACHE) ? rdata_i : '0;
  assign d_rvalid_o = in_rdata & (owner_q == ID_DCACHE) & rvalid_i;
  assign d_rlast_o  = in_rdata & (owner_q == ID_DCACHE) & rlast_i;
  assign d_rdata_o  = (in_rdata && owner_q == ID_DCACHE) ? rdata_i : '0;
  assign err_o      = err_q;

  assign awvalid_o   = (w_state_q == W_ADDR);
  assign d_awready_o = awvalid_o & awready_i;
  assign awid_o      = 4'd0;
  assign awaddr_o    = awaddr_q;
  assign awlen_o     = awlen_q;
  assign awsize_o    = awsize_q;
  assign awburst_o   = BURST_INCR;
  assign awlock_o    = 2'b00;
  assign awcache_o   = 4'b0000;
  assign awprot_o    = 3'b000;
  assign wid_o       = 4'd0;
  assign wvalid_o    = in_wdata & d_wvalid_i;
  assign wdata_o     = in_wdata ? d_wdata_i : '0;
  assign wstrb_o     = in_wdata ? d_wstrb_i : '0;
  assign wlast_o     = in_wdata & d_wlast_i;
  assign d_wready_o  = in_wdata & wready_i;
  assign d_bvalid_o  = in_wresp & bvalid_i;
  assign bready_o    = in_wresp & d_bready_i;

endmodule

// File: tb/tb_axi_burst_scheduler.sv
// Self-checking bench: table of read bursts, AR scoreboard, hand sequences for corner cases.
module tb_axi_burst_scheduler;

  logic        clk_i = 1'b0, rst_ni;
  logic [31:0] i_araddr_i, d_araddr_i, d_awaddr_i, d_wdata_i, rdata_i;
  logic [3:0]  i_arlen_i, d_arlen_i, d_awlen_i, d_wstrb_i, rid_i, bid_i;
  logic [2:0]  d_arsize_i, d_awsize_i;
  logic [1:0]  rresp_i, bresp_i;
  logic i_arvalid_i, i_rready_i, d_arvalid_i, d_rready_i, d_awvalid_i, d_wlast_i, d_wvalid_i;
  logic d_bready_i, arready_i, rlast_i, rvalid_i, awready_i, wready_i, bvalid_i;
  logic        i_arready_o, i_rlast_o, i_rvalid_o, d_arready_o, d_rlast_o, d_rvalid_o;
  logic        d_awready_o, d_wready_o, d_bvalid_o, arvalid_o, rready_o, awvalid_o;
  logic        wlast_o, wvalid_o, bready_o, err_o;
  logic [31:0] i_rdata_o, d_rdata_o, araddr_o, awaddr_o, wdata_o;
  logic [3:0]  arid_o, arlen_o, arcache_o, awid_o, awlen_o, awcache_o, wid_o, wstrb_o;
  logic [2:0]  arsize_o, arprot_o, awsize_o, awprot_o;
  logic [1:0]  arburst_o, arlock_o, awburst_o, awlock_o;

  axi_burst_scheduler #(.LINE_OFF(5)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .i_araddr_i(i_araddr_i), .i_arlen_i(i_arlen_i), .i_arvalid_i(i_arvalid_i),
    .i_arready_o(i_arready_o), .i_rdata_o(i_rdata_o), .i_rlast_o(i_rlast_o),
    .i_rvalid_o(i_rvalid_o), .i_rready_i(i_rready_i),
    .d_araddr_i(d_araddr_i), .d_arlen_i(d_arlen_i), .d_arsize_i(d_arsize_i),
    .d_arvalid_i(d_arvalid_i), .d_arready_o(d_arready_o), .d_rdata_o(d_rdata_o),
    .d_rlast_o(d_rlast_o), .d_rvalid_o(d_rvalid_o), .d_rready_i(d_rready_i),
    .d_awaddr_i(d_awaddr_i), .d_awlen_i(d_awlen_i), .d_awsize_i(d_awsize_i),
    .d_awvalid_i(d_awvalid_i), .d_awready_o(d_awready_o),
    .d_wdata_i(d_wdata_i), .d_wstrb_i(d_wstrb_i), .d_wlast_i(d_wlast_i),
    .d_wvalid_i(d_wvalid_i), .d_wready_o(d_wready_o),
    .d_bvalid_o(d_bvalid_o), .d_bready_i(d_bready_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o), .arsize_o(arsize_o),
    .arburst_o(arburst_o), .arlock_o(arlock_o), .arcache_o(arcache_o), .arprot_o(arprot_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .rid_i(rid_i), .rdata_i(rdata_i), .rresp_i(rresp_i), .rlast_i(rlast_i),
    .rvalid_i(rvalid_i), .rready_o(rready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o), .awsize_o(awsize_o),
    .awburst_o(awburst_o), .awlock_o(awlock_o), .awcache_o(awcache_o), .awprot_o(awprot_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .wid_o(wid_o), .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wlast_o(wlast_o),
    .wvalid_o(wvalid_o), .wready_i(wready_i),
    .bid_i(bid_i), .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o),
    .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        who;
    logic [31:0] addr;
    logic [3:0]  len;
    int          stall;
    int          last_at;
    logic        exp_err;
  } rd_vec_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [3:0]  len;
  } ar_exp_t;

  ar_exp_t sb[$];
  rd_vec_t tbl[5];
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_ar(input logic who, input logic [31:0] addr, input logic [3:0] len);
    ar_exp_t e;
    e.id = {3'b000, who};
    e.addr = addr;
    e.len = len;
    sb.push_back(e);
  endtask

  always @(negedge clk_i) begin
    ar_exp_t e;
    if (rst_ni && arvalid_o && arready_i) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL ar_unexpected: got addr %h want none", araddr_o);
      end else begin
        e = sb.pop_front();
        check("sb_arid", arid_o, e.id);
        check("sb_araddr", araddr_o, e.addr);
        check("sb_arlen", arlen_o, e.len);
      end
    end
  end

  task automatic run_read(input rd_vec_t v);
    int pulses;
    logic [31:0] pat;
    push_ar(v.who, v.addr, v.len);
    if (v.who) begin
      d_araddr_i = v.addr; d_arlen_i = v.len; d_arsize_i = 3'b010; d_arvalid_i = 1'b1;
    end else begin
      i_araddr_i = v.addr; i_arlen_i = v.len; i_arvalid_i = 1'b1;
    end
    tick();
    check("ar_latency", arvalid_o, 1'b1);
    pulses = 0;
    for (int s = 0; s < v.stall; s++) begin
      arready_i = 1'b0;
      #1;
      check("stall_arvalid", arvalid_o, 1'b1);
      check("stall_araddr", araddr_o, v.addr);
      check("stall_arlen", arlen_o, v.len);
      pulses += int'(v.who ? d_arready_o : i_arready_o);
      tick();
    end
    arready_i = 1'b1;
    #1;
    pulses += int'(v.who ? d_arready_o : i_arready_o);
    check("other_arready", v.who ? i_arready_o : d_arready_o, 1'b0);
    tick();
    arready_i = 1'b0;
    i_arvalid_i = 1'b0;
    d_arvalid_i = 1'b0;
    check("arready_pulses", pulses, 1);
    if (v.who) d_rready_i = 1'b1; else i_rready_i = 1'b1;
    for (int b = 0; b <= v.last_at; b++) begin
      pat = 32'hA500_0000 + v.addr[15:0] + b;
      rvalid_i = 1'b1;
      rdata_i = pat;
      rlast_i = (b == v.last_at);
      #1;
      check("own_rvalid", v.who ? d_rvalid_o : i_rvalid_o, 1'b1);
      check("own_rdata", v.who ? d_rdata_o : i_rdata_o, pat);
      check("own_rlast", v.who ? d_rlast_o : i_rlast_o, b == v.last_at);
      check("other_rvalid", v.who ? i_rvalid_o : d_rvalid_o, 1'b0);
      check("rready", rready_o, 1'b1);
      tick();
    end
    rvalid_i = 1'b0;
    rlast_i = 1'b0;
    #1;
    check("err", err_o, v.exp_err);
    check("idle_rready", rready_o, 1'b0);
    i_rready_i = 1'b0;
    d_rready_i = 1'b0;
  endtask

  initial begin
    rst_ni = 1'b0;
    {i_araddr_i, d_araddr_i, d_awaddr_i, d_wdata_i, rdata_i} = '0;
    {i_arlen_i, d_arlen_i, d_awlen_i, d_wstrb_i, rid_i, bid_i} = '0;
    {d_arsize_i, d_awsize_i, rresp_i, bresp_i} = '0;
    {i_arvalid_i, i_rready_i, d_arvalid_i, d_rready_i, d_awvalid_i, d_wlast_i, d_wvalid_i} = '0;
    {d_bready_i, arready_i, rlast_i, rvalid_i, awready_i, wready_i, bvalid_i} = '0;

    tbl[0] = '{1'b0, 32'h1FC0_0000, 4'd7, 0, 7, 1'b0};
    tbl[1] = '{1'b1, 32'h0000_4000, 4'd3, 2, 3, 1'b0};
    tbl[2] = '{1'b0, 32'h0000_0100, 4'd0, 0, 0, 1'b0};
    tbl[3] = '{1'b1, 32'h1234_5678, 4'd15, 5, 15, 1'b0};
    tbl[4] = '{1'b0, 32'h0000_0200, 4'd7, 0, 3, 1'b1};

    tick(); tick();
    check("rst_ar_side", {arvalid_o, rready_o, i_arready_o, d_arready_o}, 4'b0);
    check("rst_r_side", {i_rvalid_o, d_rvalid_o, i_rlast_o, d_rlast_o}, 4'b0);
    check("rst_w_side", {awvalid_o, wvalid_o, bready_o, d_awready_o, d_wready_o, d_bvalid_o}, 6'b0);
    check("rst_err", err_o, 1'b0);
    rst_ni = 1'b1;
    tick();

    // contention right after reset: dcache first, icache after one bubble
    push_ar(1'b1, 32'h0000_8000, 4'd1);
    push_ar(1'b0, 32'h0000_9000, 4'd0);
    d_araddr_i = 32'h0000_8000; d_arlen_i = 4'd1; d_arsize_i = 3'b010; d_arvalid_i = 1'b1;
    i_araddr_i = 32'h0000_9000; i_arlen_i = 4'd0; i_arvalid_i = 1'b1;
    tick();
    check("cont_arid_first", arid_o, 4'd1);
    arready_i = 1'b1;
    #1;
    check("cont_d_arready", d_arready_o, 1'b1);
    check("cont_i_arready", i_arready_o, 1'b0);
    tick();
    arready_i = 1'b0; d_arvalid_i = 1'b0; d_rready_i = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'h1111_0000; rlast_i = 1'b0;
    tick();
    rlast_i = 1'b1; rdata_i = 32'h1111_0001;
    #1;
    check("cont_d_rlast", d_rlast_o, 1'b1);
    check("cont_i_quiet", i_rvalid_o, 1'b0);
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0; d_rready_i = 1'b0;
    check("cont_bubble", arvalid_o, 1'b0);
    tick();
    check("cont_rerise", arvalid_o, 1'b1);
    check("cont_arid_second", arid_o, 4'd0);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; i_arvalid_i = 1'b0; i_rready_i = 1'b1;
    rvalid_i = 1'b1; rlast_i = 1'b1; rdata_i = 32'h2222_0000;
    #1;
    check("cont_i_rvalid", i_rvalid_o, 1'b1);
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0; i_rready_i = 1'b0;
    tick();

    foreach (tbl[k]) run_read(tbl[k]);
    tick();

    // write stalled in W_RESP blocks the same-line dcache read only
    d_awaddr_i = 32'h8000_1000; d_awlen_i = 4'd0; d_awsize_i = 3'b010; d_awvalid_i = 1'b1;
    tick();
    d_awvalid_i = 1'b0;
    check("wr_awvalid", awvalid_o, 1'b1);
    check("wr_awaddr", awaddr_o, 32'h8000_1000);
    check("wr_wready_early", d_wready_o, 1'b0);
    awready_i = 1'b1;
    #1;
    check("wr_d_awready", d_awready_o, 1'b1);
    tick();
    awready_i = 1'b0;
    d_wvalid_i = 1'b1; d_wlast_i = 1'b1; d_wdata_i = 32'hDEAD_BEEF; d_wstrb_i = 4'hF; wready_i = 1'b1;
    #1;
    check("wr_wvalid", wvalid_o, 1'b1);
    check("wr_wdata", wdata_o, 32'hDEAD_BEEF);
    check("wr_d_wready", d_wready_o, 1'b1);
    tick();
    d_wvalid_i = 1'b0; d_wlast_i = 1'b0; wready_i = 1'b0;
    check("wr_resp_wvalid", wvalid_o, 1'b0);
    push_ar(1'b0, 32'h8000_2000, 4'd0);
    push_ar(1'b1, 32'h8000_1010, 4'd0);
    d_araddr_i = 32'h8000_1010; d_arlen_i = 4'd0; d_arsize_i = 3'b010; d_arvalid_i = 1'b1;
    i_araddr_i = 32'h8000_2000; i_arlen_i = 4'd0; i_arvalid_i = 1'b1;
    tick();
    check("haz_arid", arid_o, 4'd0);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; i_arvalid_i = 1'b0; i_rready_i = 1'b1;
    rvalid_i = 1'b1; rlast_i = 1'b1;
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0; i_rready_i = 1'b0;
    tick(); tick();
    check("haz_held", arvalid_o, 1'b0);
    bvalid_i = 1'b1; d_bready_i = 1'b1;
    #1;
    check("wr_d_bvalid", d_bvalid_o, 1'b1);
    check("wr_bready", bready_o, 1'b1);
    tick();
    bvalid_i = 1'b0; d_bready_i = 1'b0;
    check("haz_not_yet", arvalid_o, 1'b0);
    tick();
    check("haz_released", arvalid_o, 1'b1);
    check("haz_arid_d", arid_o, 4'd1);
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; d_arvalid_i = 1'b0; d_rready_i = 1'b1;
    rvalid_i = 1'b1; rlast_i = 1'b1;
    tick();
    rvalid_i = 1'b0; rlast_i = 1'b0; d_rready_i = 1'b0;
    check("err_sticky", err_o, 1'b1);
    tick();

    // reset in the middle of a data phase
    push_ar(1'b0, 32'h0000_0040, 4'd3);
    i_araddr_i = 32'h0000_0040; i_arlen_i = 4'd3; i_arvalid_i = 1'b1;
    tick();
    arready_i = 1'b1;
    tick();
    arready_i = 1'b0; i_arvalid_i = 1'b0; i_rready_i = 1'b1;
    rvalid_i = 1'b1; rdata_i = 32'h0000_1234; rlast_i = 1'b0;
    tick();
    #2;
    rst_ni = 1'b0;
    #1;
    check("rst_mid_rvalid", i_rvalid_o, 1'b0);
    check("rst_mid_rdata", i_rdata_o, 32'h0);
    check("rst_mid_rready", rready_o, 1'b0);
    check("rst_mid_err", err_o, 1'b0);
    rvalid_i = 1'b0; i_rready_i = 1'b0;
    tick(); tick();
    rst_ni = 1'b1;
    tick();
    run_read('{1'b0, 32'h0000_0080, 4'd2, 1, 2, 1'b0});
    tick();
    run_read('{1'b1, 32'h0000_0300, 4'd1, 0, 2, 1'b1});
    tick();

    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
